// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART transmit framer: parity mode
//             encodings and the framer state enumeration.
//  Contents : PAR_NONE / PAR_ODD / PAR_EVEN / PAR_MARK  (2-bit codes)
//             uart_state_t                              (3-bit FSM states)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/parity_calc.sv
`default_nettype none
// ============================================================================
//  Module   : parity_calc
//  Purpose  : Combinational parity bit generator for one UART payload.
//  Ports    : payload_i     [DATA_WIDTH-1:0]  payload to protect
//             parity_type_i [1:0]             PAR_NONE/ODD/EVEN/MARK
//             parity_bit_o                    bit to transmit in the parity slot
//  Revision : 1.0  initial release
// ============================================================================
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] payload_i,
    input  logic [1:0]            parity_type_i,
    output logic                  parity_bit_o
);

    logic w_xor;

    assign w_xor = ^payload_i;

    always_comb begin
        parity_bit_o = 1'b0;
        case (parity_type_i)
            PAR_ODD:  parity_bit_o = ~w_xor;
            PAR_EVEN: parity_bit_o = w_xor;
            PAR_MARK: parity_bit_o = 1'b1;
            default:  parity_bit_o = 1'b0;   // no parity slot is sent
        endcase
    end

endmodule : parity_calc
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_framer
//  Purpose  : UART transmit framer. Serialises one payload per accepted
//             request as start bit, DATA_WIDTH data bits (LSB first), an
//             optional parity bit and one or two stop bits.
//  Ports    : clk          clock, rising edge
//             rst          synchronous active-high reset
//             data_in      payload, latched on accept
//             parity_type  00 none, 01 odd, 10 even, 11 mark; latched on accept
//             stop_bits    0 = one stop bit, 1 = two; latched on accept
//             tx_valid     send request
//             tx_ready     high only while idle; accept = tx_valid & tx_ready
//             tx_out       serial line, idle high
//             busy         high while a frame is in progress
//             done         one-cycle pulse in the first idle cycle after a frame
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            parity_type,
    input  logic                  stop_bits,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam int C_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [C_CNT_W-1:0] C_CNT_RELOAD = C_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(DATA_WIDTH - 1);

    uart_state_t             state_q;
    logic [C_CNT_W-1:0]      cnt_q;        // cycles left in the current bit
    logic [C_IDX_W-1:0]      bit_idx_q;    // data bit currently on the line
    logic [DATA_WIDTH-1:0]   data_q;       // payload as accepted (parity source)
    logic [DATA_WIDTH-1:0]   shift_q;      // payload bits still to be sent
    logic [1:0]              par_type_q;
    logic                    stop2_q;
    logic                    stop_left_q;  // a second stop bit follows this one
    logic                    tx_out_q;
    logic                    tx_ready_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    w_bit_end;
    logic                    w_parity;

    assign w_bit_end = (cnt_q == '0);

    // Parity is derived from the latched payload so that input changes while
    // busy cannot reach the line.
    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .payload_i     (data_q),
        .parity_type_i (par_type_q),
        .parity_bit_o  (w_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            data_q      <= '0;
            shift_q     <= '0;
            par_type_q  <= '0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            tx_out_q    <= 1'b1;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        data_q     <= data_in;
                        shift_q    <= data_in;
                        par_type_q <= parity_type;
                        stop2_q    <= stop_bits;
                        cnt_q      <= C_CNT_RELOAD;
                        tx_out_q   <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        cnt_q     <= C_CNT_RELOAD;
                        bit_idx_q <= '0;
                        tx_out_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        state_q   <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        cnt_q <= C_CNT_RELOAD;
                        if (bit_idx_q == C_IDX_LAST) begin
                            bit_idx_q <= '0;
                            if (par_type_q != PAR_NONE) begin
                                tx_out_q <= w_parity;
                                state_q  <= ST_PARITY;
                            end else begin
                                tx_out_q    <= 1'b1;
                                stop_left_q <= stop2_q;
                                state_q     <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + C_IDX_W'(1);
                            tx_out_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q - C_CNT_W'(1);
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        cnt_q       <= C_CNT_RELOAD;
                        tx_out_q    <= 1'b1;
                        stop_left_q <= stop2_q;
                        state_q     <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_W'(1);
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                            cnt_q       <= C_CNT_RELOAD;
                        end else begin
                            // Counter is already zero here, matching its idle value.
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - C_CNT_W'(1);
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    tx_out_q   <= 1'b1;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : uart_tx_framer
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_framer
//  Purpose  : Directed self-checking bench for uart_tx_framer with
//             DATA_WIDTH = 8 and CLKS_PER_BIT = 4. Expected line waveforms
//             are written by hand as bit-slot sequences (first slot in the
//             MSB) and expanded to one entry per clock cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    parity_type = 2'b00;
    logic          stop_bits = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_out;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_framer #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Expand a slot sequence (first slot in bit nbits-1) to one bit per cycle.
    function automatic logic [63:0] expand(input logic [15:0] seq, input int nbits);
        logic [63:0] e;
        e = '0;
        for (int s = 0; s < nbits; s++)
            for (int c = 0; c < CPB; c++)
                e[s*CPB + c] = seq[nbits-1-s];
        return e;
    endfunction

    // Wait (bounded) for tx_ready, present a request and let it be accepted.
    task automatic start_frame(input logic [DW-1:0] d, input logic [1:0] p,
                               input logic s, input bit keep_valid);
        int waited;
        waited = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: tx_ready=%b required 1 within 200 cycles", tx_ready);
        end
        data_in     = d;
        parity_type = p;
        stop_bits   = s;
        tx_valid    = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Record tx_out for n cycles after an accept edge; optionally scramble
    // inputs while the frame is in flight.
    task automatic capture(input int n, input bit scribble, output logic [63:0] cap,
                           output int busy_bad, output int done_bad);
        cap      = '0;
        busy_bad = 0;
        done_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[i] = tx_out;
            if (busy !== 1'b1 || tx_ready !== 1'b0) busy_bad++;
            if (done !== 1'b0) done_bad++;
            if (scribble && i < n - 1) begin
                data_in     = DW'($urandom_range(255, 0));
                parity_type = 2'($urandom_range(3, 0));
                stop_bits   = 1'($urandom_range(1, 0));
                tx_valid    = 1'($urandom_range(1, 0));
            end
        end
        if (scribble) tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tx_out   !== 1'b1) begin n_fail++; $display("FAIL reset_tx_out: got %b required 1", tx_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
        n_cmp++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done     !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_frame_modes();
        // A5 even 1 stop, A5 odd 2 stop, 3C none 1 stop, 3C mark 1 stop
        logic [DW-1:0] vd [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h3C};
        logic [1:0]    vp [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic          vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0]   vq [4] = '{16'b01010010101, 16'b010100101111,
                                  16'b0001111001,  16'b00011110011};
        int            vn [4] = '{11, 12, 10, 11};
        logic [63:0] cap;
        logic [63:0] exp_w;
        int busy_bad, done_bad;
        for (int k = 0; k < 4; k++) begin
            start_frame(vd[k], vp[k], vs[k], 1'b0);
            capture(vn[k] * CPB, 1'b0, cap, busy_bad, done_bad);
            exp_w = expand(vq[k], vn[k]);
            n_cmp++; if (cap !== exp_w) begin n_fail++; $display("FAIL frame%0d_line: got %h required %h", k, cap, exp_w); end
            n_cmp++; if (busy_bad !== 0) begin n_fail++; $display("FAIL frame%0d_busy: %0d cycles not busy, required 0", k, busy_bad); end
            n_cmp++; if (done_bad !== 0) begin n_fail++; $display("FAIL frame%0d_early_done: %0d pulses, required 0", k, done_bad); end
            @(negedge clk);
            n_cmp++; if (done     !== 1'b1) begin n_fail++; $display("FAIL frame%0d_done: got %b required 1", k, done); end
            n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL frame%0d_ready: got %b required 1", k, tx_ready); end
            n_cmp++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL frame%0d_idle_busy: got %b required 0", k, busy); end
            n_cmp++; if (tx_out   !== 1'b1) begin n_fail++; $display("FAIL frame%0d_idle_line: got %b required 1", k, tx_out); end
            @(negedge clk);
            n_cmp++; if (done     !== 1'b0) begin n_fail++; $display("FAIL frame%0d_done_width: got %b required 0", k, done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] cap;
        int busy_bad, done_bad;
        start_frame(8'h55, 2'b00, 1'b0, 1'b1);
        data_in = 8'hAA;                         // next payload, valid stays high
        capture(10 * CPB, 1'b0, cap, busy_bad, done_bad);
        n_cmp++; if (cap !== expand(16'b0101010101, 10)) begin n_fail++; $display("FAIL b2b_first_line: got %h required %h", cap, expand(16'b0101010101, 10)); end
        n_cmp++; if (busy_bad + done_bad !== 0) begin n_fail++; $display("FAIL b2b_first_flags: got %0d bad cycles required 0", busy_bad + done_bad); end
        @(negedge clk);
        n_cmp++; if ({tx_out, done, tx_ready} !== 3'b111) begin n_fail++; $display("FAIL b2b_gap: tx_out/done/ready got %b required 111", {tx_out, done, tx_ready}); end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        capture(10 * CPB, 1'b0, cap, busy_bad, done_bad);
        n_cmp++; if (cap !== expand(16'b0010101011, 10)) begin n_fail++; $display("FAIL b2b_second_line: got %h required %h", cap, expand(16'b0010101011, 10)); end
        n_cmp++; if (busy_bad + done_bad !== 0) begin n_fail++; $display("FAIL b2b_second_flags: got %0d bad cycles required 0", busy_bad + done_bad); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b required 1", done); end
    endtask

    task automatic test_ignore_busy();
        logic [63:0] cap;
        int busy_bad, done_bad;
        // 0x96 odd parity, one stop bit: 0 | 0 1 1 0 1 0 0 1 | 1 | 1
        start_frame(8'h96, 2'b01, 1'b0, 1'b0);
        capture(11 * CPB, 1'b1, cap, busy_bad, done_bad);
        n_cmp++; if (cap !== expand(16'b00110100111, 11)) begin n_fail++; $display("FAIL busy_ignore_line: got %h required %h", cap, expand(16'b00110100111, 11)); end
        n_cmp++; if (busy_bad + done_bad !== 0) begin n_fail++; $display("FAIL busy_ignore_flags: got %0d bad cycles required 0", busy_bad + done_bad); end
        @(negedge clk);
        n_cmp++; if ({tx_out, done, tx_ready} !== 3'b111) begin n_fail++; $display("FAIL busy_ignore_end: tx_out/done/ready got %b required 111", {tx_out, done, tx_ready}); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_no_restart: busy got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] cap;
        int busy_bad, done_bad;
        int done_cnt;
        start_frame(8'hA5, 2'b10, 1'b0, 1'b0);
        repeat (18) @(negedge clk);              // inside data bit 3 (line low)
        n_cmp++; if (tx_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: tx_out got %b required 0", tx_out); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx_out   !== 1'b1) begin n_fail++; $display("FAIL rst_mid_line: got %b required 1", tx_out); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b required 1", tx_ready); end
        n_cmp++; if (busy     !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        n_cmp++; if (done     !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b required 0", done); end
        // Reset wins over a request presented in the same cycle.
        rst      = 1'b1;
        tx_valid = 1'b1;
        data_in  = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        tx_valid = 1'b0;
        n_cmp++; if ({busy, tx_out} !== 2'b01) begin n_fail++; $display("FAIL rst_priority: busy/tx_out got %b required 01", {busy, tx_out}); end
        done_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_cnt++;
        end
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_quiet: %0d active cycles, required 0", done_cnt); end
        start_frame(8'hFF, 2'b10, 1'b0, 1'b0);
        capture(11 * CPB, 1'b0, cap, busy_bad, done_bad);
        n_cmp++; if (cap !== expand(16'b01111111101, 11)) begin n_fail++; $display("FAIL rst_after_line: got %h required %h", cap, expand(16'b01111111101, 11)); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_after_done: got %b required 1", done); end
    endtask

    initial begin
        test_reset();
        test_frame_modes();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_framer
`default_nettype wire

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame, legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal range 2..65535.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  DATA_WIDTH  payload, sampled on accept.
REQ-006 parity_type  input  2  00 none, 01 odd, 10 even, 11 mark (constant 1); sampled on accept.
REQ-007 stop_bits  input  1  0 = one stop bit, 1 = two stop bits; sampled on accept.
REQ-008 tx_valid  input  1  request to send data_in.
REQ-009 tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready on a rising edge.
REQ-010 tx_out  output  1  serial line, idle high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 On accept, data_in, parity_type and stop_bits SHALL be latched; FSM enters START; tx_out goes low in the next cycle.
REQ-015 Each of START, every DATA bit, PARITY and every STOP bit SHALL hold tx_out for exactly CLKS_PER_BIT cycles, timed by an internal down-counter reloaded at each bit boundary.
REQ-016 DATA SHALL shift the latched payload LSB first, DATA_WIDTH bits; a bit index counter wraps to 0 on exit.
REQ-017 PARITY SHALL be skipped when the latched parity_type = 00.
REQ-018 Parity bit: even = XOR of the payload bits; odd = inverted XOR; mark = 1.
REQ-019 STOP SHALL drive tx_out high for 1 or 2 bit periods per latched stop_bits.
REQ-020 Frame length SHALL be (1 + DATA_WIDTH + P + S) x CLKS_PER_BIT cycles, P in {0,1}, S in {1,2}.
REQ-021 On the last cycle of the last stop bit, the FSM SHALL return to IDLE; done SHALL be high in the first IDLE cycle, coincident with tx_ready rising.
REQ-022 A request accepted in that first IDLE cycle SHALL start the next frame; minimum inter-frame idle is exactly one cycle of tx_out high.
REQ-023 tx_valid, data_in and mode-input changes while busy SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-024 tx_valid held high continuously SHALL produce back-to-back frames with one idle cycle between them.

Reset
REQ-025 When rst is high at a rising edge: state = IDLE, tx_out = 1, tx_ready = 1, busy = 0, done = 0, counters = 0, latched registers = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; no done pulse; tx_out returns high on the next edge.
REQ-027 rst SHALL take priority over a simultaneous accept.

Structure
REQ-028 Shared package uart_pkg SHALL hold the parity_type encodings (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_MARK) and the FSM state enumeration.
REQ-029 Parity computation SHALL be a combinational sub-module parity_calc (inputs: payload, parity_type; output: parity bit), parametrised by DATA_WIDTH.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to tx_out.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-031 data 0xA5, even, 1 stop -> tx_out 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; 44 cycles; done at cycle 45.
REQ-032 data 0xA5, odd, 2 stop -> parity bit 1; stop high for 8 cycles; total 48 cycles.
REQ-033 data 0x3C, none, 1 stop -> no parity slot; 40 cycles; mark mode with the same data -> parity bit 1.
REQ-034 tx_valid held high with 0x55 then 0xAA -> two frames separated by exactly one idle-high cycle; done pulses once per frame.
REQ-035 data_in and parity_type toggled randomly while busy -> transmitted frame matches the values latched at accept.
REQ-036 rst asserted during DATA bit 3 -> tx_out high and tx_ready high next cycle, no done; a subsequent 0xFF even frame is correct.
